// File: rtl/display_arbiter.sv
// Two-requester display arbiter driving a multiplexed two-digit active-low
// 7-segment display with blanking and a minimum grant tenure in refresh slots.
module display_arbiter #(
  parameter int REFRESH_DIV  = 5000,
  parameter int BLANK_CYCLES = 16,
  parameter int HOLD_SLOTS   = 200
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       req_a,
  input  logic       req_b,
  input  logic [7:0] data_a,
  input  logic [7:0] data_b,
  output logic       grant_a,
  output logic       grant_b,
  output logic [6:0] seg,
  output logic       ca
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_A = 2'd1,
    GNT_B = 2'd2
  } state_e;

  localparam logic [15:0] PRESC_LAST = 16'(REFRESH_DIV - 1);
  localparam logic [15:0] BLANK_END  = 16'(BLANK_CYCLES);
  localparam logic [9:0]  HOLD_MAX   = 10'(HOLD_SLOTS);
  localparam logic [6:0]  SEG_OFF    = 7'h7F;

  state_e      state_q, state_d;
  logic        last_q, last_d;         // 1 = B was granted most recently
  logic [15:0] presc_q, presc_d;
  logic [9:0]  hold_q, hold_d;
  logic        ca_q, ca_d;
  logic [6:0]  seg_q, seg_d;
  logic [7:0]  disp_q, disp_d;
  logic        grant_a_q, grant_a_d;
  logic        grant_b_q, grant_b_d;

  logic        slot_tick;
  logic        hold_done;
  logic        entry;
  logic        blank;
  logic [3:0]  nibble;

  function automatic logic [6:0] glyph(input logic [3:0] n);
    case (n)
      4'h0: glyph = 7'h40;
      4'h1: glyph = 7'h79;
      4'h2: glyph = 7'h24;
      4'h3: glyph = 7'h30;
      4'h4: glyph = 7'h19;
      4'h5: glyph = 7'h12;
      4'h6: glyph = 7'h02;
      4'h7: glyph = 7'h78;
      4'h8: glyph = 7'h00;
      4'h9: glyph = 7'h10;
      4'hA: glyph = 7'h08;
      4'hB: glyph = 7'h03;
      4'hC: glyph = 7'h46;
      4'hD: glyph = 7'h21;
      4'hE: glyph = 7'h06;
      default: glyph = 7'h0E;
    endcase
  endfunction

  // NOTE: every signal assigned here gets a default first so no latch is inferred.
  always_comb begin
    slot_tick = (presc_q == PRESC_LAST);
    hold_done = (hold_q == HOLD_MAX);
    presc_d   = slot_tick ? 16'd0 : presc_q + 16'd1;
    ca_d      = ca_q ^ slot_tick;

    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req_a && req_b) state_d = last_q ? GNT_A : GNT_B;
        else if (req_a)     state_d = GNT_A;
        else if (req_b)     state_d = GNT_B;
      end
      GNT_A: begin
        if (hold_done) begin
          if (req_b)       state_d = GNT_B;
          else if (!req_a) state_d = IDLE;
        end
      end
      GNT_B: begin
        if (hold_done) begin
          if (req_a)       state_d = GNT_A;
          else if (!req_b) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    entry  = (state_d != IDLE) && (state_d != state_q);
    last_d = entry ? (state_d == GNT_B) : last_q;

    hold_d = hold_q;
    if (entry)                       hold_d = 10'd0;
    else if (slot_tick && !hold_done) hold_d = hold_q + 10'd1;

    // A direct switch shows the new owner's byte from its first granted cycle.
    disp_d = disp_q;
    if (entry && state_q != IDLE)        disp_d = (state_d == GNT_A) ? data_a : data_b;
    else if (state_q == GNT_A && req_a)  disp_d = data_a;
    else if (state_q == GNT_B && req_b)  disp_d = data_b;

    grant_a_d = (state_d == GNT_A);
    grant_b_d = (state_d == GNT_B);

    nibble = ca_d ? disp_d[7:4] : disp_d[3:0];
    blank  = (state_d == IDLE) || (presc_d < BLANK_END) || (presc_d == PRESC_LAST);
    seg_d  = blank ? SEG_OFF : glyph(nibble);
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q   <= IDLE;
      last_q    <= 1'b1;
      presc_q   <= 16'd0;
      hold_q    <= 10'd0;
      ca_q      <= 1'b0;
      seg_q     <= SEG_OFF;
      disp_q    <= 8'h00;
      grant_a_q <= 1'b0;
      grant_b_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      presc_q   <= presc_d;
      hold_q    <= hold_d;
      ca_q      <= ca_d;
      seg_q     <= seg_d;
      disp_q    <= disp_d;
      grant_a_q <= grant_a_d;
      grant_b_q <= grant_b_d;
    end
  end

  assign grant_a = grant_a_q;
  assign grant_b = grant_b_q;
  assign seg     = seg_q;
  assign ca      = ca_q;

endmodule

// File: tb/tb_display_arbiter.sv
// Self-checking bench for display_arbiter: directed scenarios plus random
// requests, every cycle compared against a cycle-count based reference model.
module tb_display_arbiter;

  localparam int DIV   = 8;
  localparam int BLANK = 2;
  localparam int HOLD  = 3;

  logic       clk = 1'b0;
  logic       rst_n, req_a, req_b;
  logic [7:0] data_a, data_b;
  logic       grant_a, grant_b, ca;
  logic [6:0] seg;

  int total = 0;
  int bad   = 0;

  // Reference model: time since reset, owner (0 none, 1 A, 2 B), tenure in slots.
  int         m_n;
  int         m_owner;
  int         m_last;
  int         m_hold;
  logic [7:0] m_disp;

  logic [6:0] glyph_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  always #5 clk = ~clk;

  display_arbiter #(.REFRESH_DIV(DIV), .BLANK_CYCLES(BLANK), .HOLD_SLOTS(HOLD)) dut (
    .CLK     (clk),
    .RST_N   (rst_n),
    .req_a   (req_a),
    .req_b   (req_b),
    .data_a  (data_a),
    .data_b  (data_b),
    .grant_a (grant_a),
    .grant_b (grant_b),
    .seg     (seg),
    .ca      (ca)
  );

  a_mutex: assert property (@(posedge clk) !(grant_a && grant_b));

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_step();
    int  nxt;
    bit  tick, done, want_a, want_b;
    if (!rst_n) begin
      m_n = 0; m_owner = 0; m_last = 2; m_hold = 0; m_disp = 8'h00;
      return;
    end
    tick   = (m_n % DIV) == DIV - 1;
    done   = (m_hold == HOLD);
    want_a = req_a;
    want_b = req_b;
    nxt    = m_owner;
    if (m_owner == 0) begin
      if (want_a && want_b) nxt = (m_last == 1) ? 2 : 1;
      else if (want_a)      nxt = 1;
      else if (want_b)      nxt = 2;
    end else if (done) begin
      if (m_owner == 1) nxt = want_b ? 2 : (want_a ? 1 : 0);
      else              nxt = want_a ? 1 : (want_b ? 2 : 0);
    end
    if (m_owner != 0 && nxt != 0 && nxt != m_owner) m_disp = (nxt == 1) ? data_a : data_b;
    else if (m_owner == 1 && want_a)                m_disp = data_a;
    else if (m_owner == 2 && want_b)                m_disp = data_b;
    if (nxt != 0 && nxt != m_owner) begin
      m_hold = 0;
      m_last = nxt;
    end else if (tick && m_hold < HOLD) begin
      m_hold++;
    end
    m_owner = nxt;
    m_n     = (m_n + 1) % (2 * DIV);
  endtask

  task automatic compare_outputs();
    int         p;
    logic       exp_ca;
    logic [3:0] nib;
    logic [6:0] exp_seg;
    p       = m_n % DIV;
    exp_ca  = ((m_n / DIV) % 2) == 1;
    nib     = exp_ca ? m_disp[7:4] : m_disp[3:0];
    exp_seg = (m_owner == 0 || p < BLANK || p == DIV - 1) ? 7'h7F : glyph_tbl[nib];
    check("grant_a", 16'(grant_a), 16'(m_owner == 1));
    check("grant_b", 16'(grant_b), 16'(m_owner == 2));
    check("mutex",   16'(grant_a & grant_b), 16'd0);
    check("ca",      16'(ca), 16'(exp_ca));
    check("seg",     16'(seg), 16'(exp_seg));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_outputs();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    run(n);
    rst_n = 1'b1;
  endtask

  initial begin
    bit found;
    rst_n = 1'b0; req_a = 1'b0; req_b = 1'b0; data_a = 8'h00; data_b = 8'h00;

    // Idle cadence.
    do_reset(3);
    check("reset_seg", 16'(seg), 16'h7F);
    check("reset_ca",  16'(ca),  16'd0);
    run(40);

    // Single owner A showing 3C.
    req_a = 1'b1; data_a = 8'h3C;
    run(60);
    req_a = 1'b0;
    run(30);

    // Contention straight after reset, alternating every HOLD slots.
    do_reset(2);
    req_a = 1'b1; req_b = 1'b1; data_a = 8'h12; data_b = 8'hEF;
    run(120);

    // Early drop of B with A5.
    req_a = 1'b0; req_b = 1'b0;
    do_reset(2);
    req_b = 1'b1; data_b = 8'hA5;
    run(2);
    req_b = 1'b0; data_b = 8'h77;
    run(50);

    // Reset mid-grant at prescaler 5 with both requests held high.
    req_a = 1'b1; req_b = 1'b1; data_a = 8'h9D; data_b = 8'h40;
    do_reset(1);
    found = 1'b0;
    for (int i = 0; i < 64 && !found; i++) begin
      cycle();
      if (m_owner == 1 && (m_n % DIV) == 5) found = 1'b1;
    end
    check("wait_p5", 16'(found), 16'd1);
    rst_n = 1'b0;
    cycle();
    check("mid_rst_grant_a", 16'(grant_a), 16'd0);
    check("mid_rst_seg",     16'(seg),     16'h7F);
    rst_n = 1'b1;
    cycle();
    check("regrant_a", 16'(grant_a), 16'd1);
    run(40);

    // Random requests, data and occasional resets.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(7) == 0) req_a = ~req_a;
      if ($urandom_range(7) == 0) req_b = ~req_b;
      if ($urandom_range(3) == 0) data_a = 8'($urandom);
      if ($urandom_range(3) == 0) data_b = 8'($urandom);
      rst_n = ($urandom_range(299) != 0);
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/display_arbiter.md
DISPLAY_ARBITER -- requirements
Module: display_arbiter

Interface
REQ-001 Parameter REFRESH_DIV, default 5000, CLK cycles per digit slot; legal range 4..65535.
REQ-002 Parameter BLANK_CYCLES, default 16, all-off cycles at the start of each slot; legal range 1..REFRESH_DIV-2.
REQ-003 Parameter HOLD_SLOTS, default 200, minimum grant tenure in slots; legal range 1..1023.
REQ-004 CLK  in  1  sole clock; all state updates on the rising edge.
REQ-005 RST_N  in  1  reset, synchronous, active-low.
REQ-006 req_a / req_b  in  1 each  display requests from requesters A and B, level-sensitive.
REQ-007 data_a / data_b  in  8 each  byte to show; [3:0] is the low digit, [7:4] is the high digit.
REQ-008 grant_a / grant_b  out  1 each  registered grant; at most one is high in any cycle.
REQ-009 seg  out  7  registered segments {g,f,e,d,c,b,a}, active-low; 7'h7F means all off.
REQ-010 ca  out  1  registered digit select: 0 = low digit, 1 = high digit.

Function
REQ-011 The prescaler SHALL count 0..REFRESH_DIV-1 and wrap to 0; slot_tick is asserted when the count equals REFRESH_DIV-1.
REQ-012 ca SHALL toggle on every slot_tick, so each digit gets exactly REFRESH_DIV cycles.
REQ-013 seg SHALL be 7'h7F during these cycles:
  - prescaler < BLANK_CYCLES;
  - state IDLE;
  - the cycle carrying a slot_tick.
REQ-014 Otherwise, seg SHALL be the hex glyph of the nibble selected by ca from disp_data, one cycle after that nibble is selected:
  - 0-3: 40, 79, 24, 30
  - 4-7: 19, 12, 02, 78
  - 8-B: 00, 10, 08, 03
  - C-F: 46, 21, 06, 0E
REQ-015 The arbiter FSM SHALL have three states: IDLE, GNT_A, GNT_B.
  - grant_a = (state == GNT_A).
  - grant_b = (state == GNT_B).
REQ-016 A 1-bit register last SHALL record the most recently granted requester; it is updated on every entry to GNT_A or GNT_B.
REQ-017 From IDLE:
  - only req_a high -> GNT_A;
  - only req_b high -> GNT_B;
  - both high -> grant the requester that is not last;
  - neither high -> stay in IDLE.
REQ-018 A hold counter SHALL clear to 0 on every grant entry, increment on slot_tick, and saturate at HOLD_SLOTS; hold_done = (counter == HOLD_SLOTS).
REQ-019 While granted with hold_done = 0, the state SHALL NOT change, regardless of either req input.
REQ-020 While granted with hold_done = 1, the next state SHALL be chosen as follows:
  - other requester high -> switch directly to the other grant state, even if the owner's req is still high;
  - else owner req high -> stay;
  - else -> IDLE.
REQ-021 While in GNT_x with req_x high, disp_data SHALL load data_x every cycle.
REQ-022 While in GNT_x with req_x low, disp_data SHALL hold its value.
REQ-023 In IDLE, disp_data SHALL hold its value.
REQ-024 On a grant switch, disp_data SHALL load the new owner's data on the first cycle of the new grant.
REQ-025 Hold counter width SHALL be 10 bits; prescaler width SHALL be 16 bits; all overflow is prevented by wrap (prescaler) or saturation (hold counter).
REQ-026 Grant switching SHALL NOT disturb the prescaler or ca; the refresh cadence is independent of arbitration.

Reset
REQ-027 When RST_N is 0 at a clock edge, the block SHALL set:
  - state IDLE;
  - grant_a = grant_b = 0;
  - seg = 7'h7F, ca = 0;
  - prescaler = 0, hold counter = 0;
  - disp_data = 8'h00;
  - last = B, so A wins the first contention.
REQ-028 Reset SHALL take effect on any cycle, including mid-slot and mid-grant; the block SHALL resume at prescaler 0 on the first edge with RST_N = 1.

Verification (REFRESH_DIV=8, BLANK_CYCLES=2, HOLD_SLOTS=3)
REQ-029 Idle cadence:
  - Stimulus: hold reset 3 cycles, release, no requests for 40 cycles.
  - Response: ca toggles every 8 cycles; seg stays 7'h7F; both grants stay 0.
REQ-030 Single owner:
  - Stimulus: req_a=1, data_a=8'h3C.
  - Response: grant_a rises 1 cycle later.
  - Response when ca=0: seg=7'h46 for prescaler 2..6, 7'h7F for prescaler 0,1,7.
  - Response when ca=1: seg=7'h30 for the same windows.
REQ-031 Contention after reset:
  - Stimulus: req_a=req_b=1 in the same cycle from IDLE.
  - Response: grant_a first; after 3 slot_ticks, grant_b with no idle cycle in between.
  - Response: alternation continues every 3 slots while both requests stay high.
REQ-032 Early drop:
  - Stimulus: req_b pulses 2 cycles with data_b=8'hA5, then goes low.
  - Response: grant_b is held until hold_done; display keeps A5 (seg 7'h12 / 7'h08); then IDLE and seg=7'h7F.
REQ-033 Reset mid-grant:
  - Stimulus: drive RST_N=0 for 1 cycle while grant_a=1 at prescaler 5.
  - Response: next cycle shows all REQ-027 values.
  - Response: with both requests still high, A is granted again.
REQ-034 Invariant, checked by assertion every cycle: grant_a & grant_b == 0.
